// File: rtl/meikyuu_pkg.sv
// Shared maze-display constants and types.
// Holds the screen bounds, sprite size and room-grid size used by both the
// player motion block and the VGA top, plus the direction/state enums and
// the button priority helper.
package meikyuu_pkg;

    localparam int H_MIN = 97;
    localparam int H_MAX = 736;
    localparam int V_MIN = 3;
    localparam int V_MAX = 482;
    localparam int SIZE  = 16;
    localparam int MAP_W = 3;
    localparam int MAP_H = 3;

    typedef logic [9:0] pix_t;
    typedef logic [2:0] room_t;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK
    } state_e;

    // Up beats down beats left beats right; only one axis moves per frame.
    function automatic dir_e pick_dir(input logic up, input logic down,
                                      input logic left, input logic right);
        if (up)         return DIR_UP;
        else if (down)  return DIR_DOWN;
        else if (left)  return DIR_LEFT;
        else if (right) return DIR_RIGHT;
        else            return DIR_NONE;
    endfunction

endpackage

// File: rtl/player_motion_if.sv
// Bus between the player motion block and the VGA top level.
//   slave  : player_motion side (buttons, frame_start, collision in;
//            position, room, busy, room_changed out)
//   master : VGA top side, the mirror image.
interface player_motion_if;
    import meikyuu_pkg::*;

    logic  frame_start;
    logic  btn_up;
    logic  btn_down;
    logic  btn_left;
    logic  btn_right;
    logic  collision;
    pix_t  x_pos;
    pix_t  y_pos;
    room_t mapa_pos_x_out;
    room_t mapa_pos_y_out;
    logic  busy;
    logic  room_changed;

    modport master (
        output frame_start, btn_up, btn_down, btn_left, btn_right, collision,
        input  x_pos, y_pos, mapa_pos_x_out, mapa_pos_y_out, busy, room_changed
    );

    modport slave (
        input  frame_start, btn_up, btn_down, btn_left, btn_right, collision,
        output x_pos, y_pos, mapa_pos_x_out, mapa_pos_y_out, busy, room_changed
    );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer followed by a stable-level
// counter. level_o follows the button only after DEBOUNCE consecutive
// synchronized samples differ from the current level.
//   clk, rst_n : clock, async active-low reset
//   btn_i      : raw asynchronous button, active-high
//   level_o    : debounced level
module btn_debounce #(
    parameter int DEBOUNCE = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // with = the synchronizer would collapse into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/player_motion.sv
// Player motion: debounces the four buttons, applies at most one move per
// frame, crosses rooms of the MAP_W x MAP_H grid at the screen edges, waits
// SETTLE cycles for the display stage to report a collision for the new
// position and undoes the whole move if it does.
//   CLOCK_25 : pixel clock
//   reset    : async active-low reset
//   bus      : player_motion_if.slave (buttons, frame_start, collision in;
//              x_pos, y_pos, room column/row, busy, room_changed out)
module player_motion #(
    parameter int STEP     = 4,
    parameter int SIZE     = meikyuu_pkg::SIZE,
    parameter int H_MIN    = meikyuu_pkg::H_MIN,
    parameter int H_MAX    = meikyuu_pkg::H_MAX,
    parameter int V_MIN    = meikyuu_pkg::V_MIN,
    parameter int V_MAX    = meikyuu_pkg::V_MAX,
    parameter int START_X  = 408,
    parameter int START_Y  = 234,
    parameter int START_MX = 1,
    parameter int START_MY = 1,
    parameter int MAP_W    = meikyuu_pkg::MAP_W,
    parameter int MAP_H    = meikyuu_pkg::MAP_H,
    parameter int DEBOUNCE = 250000,
    parameter int SETTLE   = 2
) (
    input logic            CLOCK_25,
    input logic            reset,
    player_motion_if.slave bus
);

    import meikyuu_pkg::*;

    localparam int CW = $clog2(SETTLE + 2);

    // Bounds in the 11-bit comparison domain so x-STEP near 0 cannot wrap.
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [10:0] X_LO   = 11'(H_MIN);
    localparam logic [10:0] X_HI   = 11'(H_MAX - SIZE + 1);
    localparam logic [10:0] Y_LO   = 11'(V_MIN);
    localparam logic [10:0] Y_HI   = 11'(V_MAX - SIZE + 1);
    localparam room_t       MX_MAX = 3'(MAP_W - 1);
    localparam room_t       MY_MAX = 3'(MAP_H - 1);

    logic   up_db, down_db, left_db, right_db;
    dir_e   dir;
    state_e state_q;
    logic [CW-1:0] cnt_q;
    pix_t   x_q, y_q, sx_q, sy_q, mv_x, mv_y;
    room_t  mx_q, my_q, smx_q, smy_q, mv_mx, mv_my;
    logic   busy_q, rc_q, move_ok;
    logic [10:0] x_ext, y_ext;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_up (
        .clk(CLOCK_25), .rst_n(reset), .btn_i(bus.btn_up),    .level_o(up_db));
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_down (
        .clk(CLOCK_25), .rst_n(reset), .btn_i(bus.btn_down),  .level_o(down_db));
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_left (
        .clk(CLOCK_25), .rst_n(reset), .btn_i(bus.btn_left),  .level_o(left_db));
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_right (
        .clk(CLOCK_25), .rst_n(reset), .btn_i(bus.btn_right), .level_o(right_db));

    assign dir   = pick_dir(up_db, down_db, left_db, right_db);
    assign x_ext = {1'b0, x_q};
    assign y_ext = {1'b0, y_q};

    // Target of the requested move; move_ok is low when the player pushes
    // against the outer wall of the room grid.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        move_ok = 1'b0;
        mv_x    = x_q;
        mv_y    = y_q;
        mv_mx   = mx_q;
        mv_my   = my_q;
        unique case (dir)
            DIR_UP: begin
                if (y_ext >= Y_LO + STEP11) begin
                    move_ok = 1'b1;
                    mv_y    = y_q - 10'(STEP);
                end else if (my_q != '0) begin
                    move_ok = 1'b1;
                    mv_y    = 10'(Y_HI);
                    mv_my   = my_q - 3'd1;
                end
            end
            DIR_DOWN: begin
                if (y_ext + STEP11 <= Y_HI) begin
                    move_ok = 1'b1;
                    mv_y    = y_q + 10'(STEP);
                end else if (my_q < MY_MAX) begin
                    move_ok = 1'b1;
                    mv_y    = 10'(Y_LO);
                    mv_my   = my_q + 3'd1;
                end
            end
            DIR_LEFT: begin
                if (x_ext >= X_LO + STEP11) begin
                    move_ok = 1'b1;
                    mv_x    = x_q - 10'(STEP);
                end else if (mx_q != '0) begin
                    move_ok = 1'b1;
                    mv_x    = 10'(X_HI);
                    mv_mx   = mx_q - 3'd1;
                end
            end
            DIR_RIGHT: begin
                if (x_ext + STEP11 <= X_HI) begin
                    move_ok = 1'b1;
                    mv_x    = x_q + 10'(STEP);
                end else if (mx_q < MX_MAX) begin
                    move_ok = 1'b1;
                    mv_x    = 10'(X_LO);
                    mv_mx   = mx_q + 3'd1;
                end
            end
            default: move_ok = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= 10'(START_X);
            y_q     <= 10'(START_Y);
            mx_q    <= 3'(START_MX);
            my_q    <= 3'(START_MY);
            // NOTE: the undo registers are reset as well, so a reset mid-move
            // leaves no stale position that a later CHECK could restore.
            sx_q    <= 10'(START_X);
            sy_q    <= 10'(START_Y);
            smx_q   <= 3'(START_MX);
            smy_q   <= 3'(START_MY);
            busy_q  <= 1'b0;
            rc_q    <= 1'b0;
        end else begin
            rc_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // frame_start in any other state is dropped, not queued.
                    if (bus.frame_start && move_ok) begin
                        sx_q    <= x_q;
                        sy_q    <= y_q;
                        smx_q   <= mx_q;
                        smy_q   <= my_q;
                        x_q     <= mv_x;
                        y_q     <= mv_y;
                        mx_q    <= mv_mx;
                        my_q    <= mv_my;
                        cnt_q   <= CW'(SETTLE);
                        busy_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Leave on the edge where the count reaches zero so that
                    // CHECK samples collision SETTLE+1 edges after the move.
                    if (cnt_q <= CW'(1)) state_q <= ST_CHECK;
                    if (cnt_q != '0)     cnt_q   <= cnt_q - CW'(1);
                end
                ST_CHECK: begin
                    if (bus.collision) begin
                        x_q  <= sx_q;
                        y_q  <= sy_q;
                        mx_q <= smx_q;
                        my_q <= smy_q;
                    end else if (mx_q != smx_q || my_q != smy_q) begin
                        rc_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.x_pos          = x_q;
    assign bus.y_pos          = y_q;
    assign bus.mapa_pos_x_out = mx_q;
    assign bus.mapa_pos_y_out = my_q;
    assign bus.busy           = busy_q;
    assign bus.room_changed   = rc_q;

endmodule

// File: doc/player_motion.md
# player_motion

Upstream stage of the maze display: turns the four raw push-buttons into one debounced move per video frame, keeps the player sprite's screen position and its room coordinates in the 3×3 room grid, and undoes any move that the display stage reports as a wall collision. Outputs feed the sprite compare, the room-select lookup and the collision generators in the VGA top level, which returns `collision` for the position currently driven.

## Interface

Parameters:
- `STEP`, 4: pixels moved per accepted frame.
- `SIZE`, 16: sprite edge length in pixels.
- `H_MIN`, 97: first active column in `h_counter` units.
- `H_MAX`, 736: last active column.
- `V_MIN`, 3: first active line.
- `V_MAX`, 482: last active line.
- `START_X`, 408: reset x position.
- `START_Y`, 234: reset y position.
- `START_MX`, 1: reset room column.
- `START_MY`, 1: reset room row.
- `MAP_W`, 3: room-grid width.
- `MAP_H`, 3: room-grid height.
- `DEBOUNCE`, 250000: stable cycles required before a button level is accepted (10 ms at 25 MHz).
- `SETTLE`, 2: cycles to wait after a move before sampling `collision`.

Ports:
- `CLOCK_25`, in, 1: pixel clock. This is the only clock.
- `reset`, in, 1: asynchronous, active-low.
- `frame_start`, in, 1: one-cycle pulse at `h_counter==0 && v_counter==0`.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, in, 1 each: raw, active-high, asynchronous.
- `collision`, in, 1: wall overlap for the currently driven position and room, valid `SETTLE` cycles after a change.
- `x_pos`, out, 10: sprite left edge.
- `y_pos`, out, 10: sprite top edge.
- `mapa_pos_x_out`, out, 3: room column.
- `mapa_pos_y_out`, out, 3: room row.
- `busy`, out, 1: high while a move is pending its collision check.
- `room_changed`, out, 1: one-cycle pulse when a room transition commits without a collision.

## Operation

- **Debounce.** Each button passes through a 2-FF synchronizer and then a stable-level counter. The debounced level changes only after `DEBOUNCE` consecutive identical synchronized samples.
- **Direction priority.** When debounced buttons are held together, priority is up > down > left > right. Only one axis moves per frame.
- **States.**
  - IDLE: on `frame_start` with a direction present, save x, y, mx and my, apply the move, load the counter with `SETTLE`, and go to SETTLE. `frame_start` with no direction does nothing.
  - SETTLE: decrement the counter. At 0, go to CHECK.
  - CHECK: if `collision` is high, restore all four saved values. Otherwise pulse `room_changed` if the room changed. Go to IDLE.
- **In-room move.**
  - up: y−STEP. down: y+STEP. left: x−STEP. right: x+STEP.
  - Applies when the result stays inside [H_MIN, H_MAX−SIZE+1] × [V_MIN, V_MAX−SIZE+1].
- **Edge crossing (up, as the pattern).** If y−STEP < V_MIN and my>0: set my−1 and y = V_MAX−SIZE+1. If my==0: no move, remain in IDLE.
- **Other edges.**
  - down: wraps to y = V_MIN with my+1, limit MAP_H−1.
  - left: wraps to x = H_MAX−SIZE+1 with mx−1, limit 0.
  - right: wraps to x = H_MIN with mx+1, limit MAP_W−1.
- **Collision after a room change.** Checked the same way. A collision reverts both position and room.
- **Arithmetic.** Unsigned, 11-bit intermediate so that x−STEP near 0 cannot wrap. Room coordinates are always kept in 0..MAP−1.

## Timing

- **Reset values.** x=START_X, y=START_Y, mx=START_MX, my=START_MY, busy=0, room_changed=0, state IDLE, debounced levels 0, synchronizers 0.
- **Move timeline.** `frame_start` is sampled at edge T and the new position is visible after T. `busy`=1 from T+1. `collision` is sampled at edge T+SETTLE+1. A revert or `room_changed` is visible after that edge. `busy`=0 from T+SETTLE+2.
- **frame_start while busy.** Ignored, not queued.
- **Button changes mid-move.** No effect on the move in progress.
- **Reset mid-move.** Immediately returns everything to the reset values. Saved values are discarded.
- **Button-to-debounced latency.** 2 + DEBOUNCE cycles.

## Structure

- Shared package `meikyuu_pkg`:
  - screen bounds H_MIN/H_MAX/V_MIN/V_MAX, SIZE and the MAP_W/MAP_H constants, also used by the VGA top;
  - a direction enum: NONE, UP, DOWN, LEFT, RIGHT;
  - a state enum: IDLE, SETTLE, CHECK.
- One sub-module `btn_debounce`, parameterized by DEBOUNCE and instantiated four times, containing the synchronizer and the counter.

## Test plan

Benches may override DEBOUNCE=4.

1. Reset low then high; no buttons; 3 `frame_start` pulses → x=408, y=234, mx=1, my=1, busy stays 0.
2. Hold btn_right; after the debounce, one `frame_start` with collision=0 → x=412 one cycle later. busy is high for 3 cycles. CHECK leaves x=412.
3. Same as scenario 2 but collision=1 at T+3 → x returns to 408 after the CHECK edge. room_changed stays 0.
4. y=3, my=1, hold btn_up, collision=0 → my=0, y=467, room_changed pulses once. Repeat from my=0, y=3 → no change, busy stays 0.
5. Press up and left together → only y changes (y−4). A button glitch shorter than DEBOUNCE → no move.
6. Assert reset during SETTLE after a move to x=412 → x=408 and busy=0 asynchronously. The next `frame_start` starts a fresh move.
